// File: rtl/acorn_pkg.sv
// acorn_pkg -- constants and phase decoding shared by the ACORN encryption and
// decryption datapaths.
//
// Contents:
//   phase_e          : step-counter phase (IDLE, DATA, PAD, ZERO, TAG, HOLD)
//   *_CNT constants  : 12-bit phase boundaries of the 4096-step counter
//   phase_of()       : decodes a count value into its phase by value only
package acorn_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_DATA = 3'd1,
    PH_PAD  = 3'd2,
    PH_ZERO = 3'd3,
    PH_TAG  = 3'd4,
    PH_HOLD = 3'd5
  } phase_e;

  localparam logic [11:0] DATA_FIRST_CNT = 12'd384;
  localparam logic [11:0] DATA_LAST_CNT  = 12'd511;
  localparam logic [11:0] PAD_CNT        = 12'd512;
  localparam logic [11:0] CA_LAST_CNT    = 12'd639;
  localparam logic [11:0] ZERO_LAST_CNT  = 12'd767;
  localparam logic [11:0] TAG_FIRST_CNT  = 12'd768;
  localparam logic [11:0] TAG_LAST_CNT   = 12'd895;
  localparam logic [11:0] HOLD_FIRST_CNT = 12'd896;

  // Pure value decode: skipped or repeated counts land in whatever phase
  // their value belongs to.
  function automatic phase_e phase_of(input logic [11:0] cnt);
    phase_e ph;
    if (cnt < DATA_FIRST_CNT)       ph = PH_IDLE;
    else if (cnt <= DATA_LAST_CNT)  ph = PH_DATA;
    else if (cnt == PAD_CNT)        ph = PH_PAD;
    else if (cnt <= ZERO_LAST_CNT)  ph = PH_ZERO;
    else if (cnt <= TAG_LAST_CNT)   ph = PH_TAG;
    else                            ph = PH_HOLD;
    return ph;
  endfunction

endpackage

// File: rtl/decryption_tag_check.sv
// decryption_tag_check -- compares the keystream produced during the TAG phase
// against an expected tag and reports the verdict once the phase is over.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   count_dp   : ACORN step counter
//   ks_bit     : keystream bit for the current count
//   tag_in     : expected 128-bit tag; bit i is compared at step 768+i
//   tag_valid  : set on the count 896 edge, cleared by rst or count 0
//   tag_ok     : 1 when every tag bit matched (valid with tag_valid)
module decryption_tag_check
  import acorn_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  count_dp,
  input  logic         ks_bit,
  input  logic [127:0] tag_in,
  output logic         tag_valid,
  output logic         tag_ok
);

  logic       mismatch_q, mismatch_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_ok_q, tag_ok_d;
  logic [6:0] tag_idx;

  assign tag_idx = 7'(count_dp - TAG_FIRST_CNT);

  always_comb begin
    mismatch_d  = mismatch_q;
    tag_valid_d = tag_valid_q;
    tag_ok_d    = tag_ok_q;
    if (count_dp == 12'd0) begin
      mismatch_d  = 1'b0;
      tag_valid_d = 1'b0;
      tag_ok_d    = 1'b0;
    end else if (phase_of(count_dp) == PH_TAG) begin
      if (ks_bit != tag_in[tag_idx]) mismatch_d = 1'b1;
    end else if (count_dp == HOLD_FIRST_CNT) begin
      // mismatch_q already holds the last TAG-step comparison here.
      tag_valid_d = 1'b1;
      tag_ok_d    = ~mismatch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_ok_q    <= 1'b0;
    end else begin
      mismatch_q  <= mismatch_d;
      tag_valid_q <= tag_valid_d;
      tag_ok_q    <= tag_ok_d;
    end
  end

  assign tag_valid = tag_valid_q;
  assign tag_ok    = tag_ok_q;

endmodule

// File: rtl/decryption.sv
// decryption -- ACORN decryption datapath. Recovers message bits from the
// ciphertext and keystream, feeds them back to the core and assembles the
// 128-bit plaintext.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   count_dp       : ACORN step counter (phase decoded from its value only)
//   ciphertext_in  : ciphertext block; bit i is decrypted at step 384+i
//   ks_bit         : keystream bit for the current count
//   mbit_out       : registered message bit fed back to the core
//   ca_out, cb_out : registered core control bits
//   plaintext_out  : assembled plaintext
//   pt_valid       : plaintext complete (set at count 512, cleared at count 0)
//   tag_in, tag_valid, tag_ok : present only with DECRYPTION_TAG_CHECK_EN
//
// Optional feature: define DECRYPTION_TAG_CHECK_EN to add tag verification.
module decryption
  import acorn_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  count_dp,
  input  logic [127:0] ciphertext_in,
  input  logic         ks_bit,
  output logic         mbit_out,
  output logic         ca_out,
  output logic         cb_out,
  output logic [127:0] plaintext_out,
`ifdef DECRYPTION_TAG_CHECK_EN
  input  logic [127:0] tag_in,
  output logic         tag_valid,
  output logic         tag_ok,
`endif
  output logic         pt_valid
);

  phase_e       phase;
  logic [6:0]   bit_idx;
  logic         dec_bit;

  logic         mbit_q, mbit_d;
  logic         ca_q, ca_d;
  logic         cb_q, cb_d;
  logic [127:0] pt_q, pt_d;
  logic         pt_valid_q, pt_valid_d;

  assign phase   = phase_of(count_dp);
  // Only meaningful inside DATA; elsewhere the truncated value is ignored.
  assign bit_idx = 7'(count_dp - DATA_FIRST_CNT);
  assign dec_bit = ciphertext_in[bit_idx] ^ ks_bit;

  always_comb begin
    mbit_d     = 1'b0;
    pt_d       = pt_q;
    pt_valid_d = pt_valid_q;
    ca_d       = (count_dp <= CA_LAST_CNT);
    cb_d       = 1'b0;

    case (phase)
      PH_DATA: begin
        mbit_d           = dec_bit;
        pt_d[bit_idx]    = dec_bit;
      end
      PH_PAD:  mbit_d = 1'b1;
      default: mbit_d = 1'b0;
    endcase

    if (count_dp == PAD_CNT)    pt_valid_d = 1'b1;
    else if (count_dp == 12'd0) pt_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mbit_q     <= 1'b0;
      ca_q       <= 1'b0;
      cb_q       <= 1'b0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
    end else begin
      mbit_q     <= mbit_d;
      ca_q       <= ca_d;
      cb_q       <= cb_d;
      pt_q       <= pt_d;
      pt_valid_q <= pt_valid_d;
    end
  end

  assign mbit_out      = mbit_q;
  assign ca_out        = ca_q;
  assign cb_out        = cb_q;
  assign plaintext_out = pt_q;
  assign pt_valid      = pt_valid_q;

`ifdef DECRYPTION_TAG_CHECK_EN
  decryption_tag_check u_tag_check (
    .clk       (clk),
    .rst       (rst),
    .count_dp  (count_dp),
    .ks_bit    (ks_bit),
    .tag_in    (tag_in),
    .tag_valid (tag_valid),
    .tag_ok    (tag_ok)
  );
`endif

endmodule

// File: tb/tb_decryption.sv
// tb_decryption -- directed bench for decryption. Sweeps count_dp with fixed
// ciphertext/keystream patterns and compares every output after each edge
// against expected values computed from the behaviour description, plus
// hand-written constants for the final plaintext and the reset state.
// Define DECRYPTION_TAG_CHECK_EN to also exercise the tag checker.
module tb_decryption;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [11:0]  count_dp = '0;
  logic [127:0] ciphertext_in = '0;
  logic         ks_bit = 1'b0;
  logic         mbit_out, ca_out, cb_out, pt_valid;
  logic [127:0] plaintext_out;
  logic [127:0] tag_vec = 128'hC3A5_0F1E_7788_9ABC_DEF0_1357_2468_ACE1;
`ifdef DECRYPTION_TAG_CHECK_EN
  logic         tag_valid, tag_ok;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // expected-state scoreboard
  logic         exp_mbit = 1'b0, exp_ca = 1'b0, exp_pv = 1'b0;
  logic [127:0] exp_pt = '0;
  logic         exp_mism = 1'b0, exp_tv = 1'b0, exp_tok = 1'b0;

  always #5 clk = ~clk;

  decryption dut (
    .clk           (clk),
    .rst           (rst),
    .count_dp      (count_dp),
    .ciphertext_in (ciphertext_in),
    .ks_bit        (ks_bit),
    .mbit_out      (mbit_out),
    .ca_out        (ca_out),
    .cb_out        (cb_out),
    .plaintext_out (plaintext_out),
`ifdef DECRYPTION_TAG_CHECK_EN
    .tag_in        (tag_vec),
    .tag_valid     (tag_valid),
    .tag_ok        (tag_ok),
`endif
    .pt_valid      (pt_valid)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one count, update the expected state, clock, then compare.
  task automatic step(input int c, input logic k, input logic r);
    count_dp = 12'(c);
    ks_bit   = k;
    rst      = r;
    if (r) begin
      exp_mbit = 1'b0; exp_ca = 1'b0; exp_pt = '0; exp_pv = 1'b0;
      exp_mism = 1'b0; exp_tv = 1'b0; exp_tok = 1'b0;
    end else begin
      exp_ca = (c <= 639);
      if (c >= 384 && c <= 511) begin
        exp_mbit = ciphertext_in[c-384] ^ k;
        exp_pt[c-384] = exp_mbit;
      end else begin
        exp_mbit = (c == 512);
      end
      if (c == 512)    exp_pv = 1'b1;
      else if (c == 0) exp_pv = 1'b0;
      if (c == 0) begin
        exp_mism = 1'b0; exp_tv = 1'b0; exp_tok = 1'b0;
      end else if (c >= 768 && c <= 895) begin
        if (k != tag_vec[c-768]) exp_mism = 1'b1;
      end else if (c == 896) begin
        exp_tv = 1'b1; exp_tok = ~exp_mism;
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("mbit@%0d", c), 128'(mbit_out), 128'(exp_mbit));
    chk($sformatf("ca@%0d", c),   128'(ca_out),   128'(exp_ca));
    chk($sformatf("cb@%0d", c),   128'(cb_out),   128'(1'b0));
    chk($sformatf("pv@%0d", c),   128'(pt_valid), 128'(exp_pv));
    chk($sformatf("pt@%0d", c),   plaintext_out,  exp_pt);
`ifdef DECRYPTION_TAG_CHECK_EN
    chk($sformatf("tv@%0d", c),   128'(tag_valid), 128'(exp_tv));
    chk($sformatf("tok@%0d", c),  128'(tag_ok),    128'(exp_tok));
`endif
  endtask

  // Sweep counts from..to. Keystream is constant ks, optionally following the
  // tag in TAG, optionally inverted at flip_at; rst is asserted at rst_at.
  task automatic sweep(input int from, input int to, input logic ks,
                       input bit tag_follow, input int flip_at, input int rst_at);
    for (int c = from; c <= to; c++) begin
      logic k;
      k = ks;
      if (tag_follow && c >= 768 && c <= 895) k = tag_vec[c-768];
      if (c == flip_at) k = ~k;
      step(c, k, c == rst_at);
    end
    rst = 1'b0;
    $display("sweep %0d..%0d ks=%0b ct=%h pt=%h pv=%0b", from, to, ks,
             ciphertext_in, plaintext_out, pt_valid);
  endtask

  initial begin
    // reset held mid-DATA
    ciphertext_in = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    step(450, 1'b1, 1'b1);
    chk("rst_mbit", 128'(mbit_out), 128'd0);
    chk("rst_ca",   128'(ca_out),   128'd0);
    chk("rst_cb",   128'(cb_out),   128'd0);
    chk("rst_pv",   128'(pt_valid), 128'd0);
    chk("rst_pt",   plaintext_out,  128'd0);
    $display("reset at count 450 pt=%h", plaintext_out);

    // all-zero ciphertext, keystream 1 -> all-ones plaintext
    ciphertext_in = '0;
    sweep(0, 1023, 1'b1, 1'b0, -1, -1);
    chk("ones_pt", plaintext_out, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("ones_pv", 128'(pt_valid), 128'd1);

    // edge bits only, keystream 0 -> plaintext equals ciphertext
    ciphertext_in = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    sweep(0, 1023, 1'b0, 1'b0, -1, -1);
    chk("edge_pt", plaintext_out, 128'h8000_0000_0000_0000_0000_0000_0000_0001);

    // reset pulse mid-DATA, then full resumed run with keystream 1
    ciphertext_in = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    sweep(0, 450, 1'b1, 1'b0, -1, 450);
    chk("mid_rst_pt", plaintext_out, 128'd0);
    chk("mid_rst_pv", 128'(pt_valid), 128'd0);
    sweep(0, 1023, 1'b1, 1'b0, -1, -1);
    chk("resume_pt", plaintext_out, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);

`ifdef DECRYPTION_TAG_CHECK_EN
    sweep(0, 1023, 1'b0, 1'b1, -1, -1);
    chk("tag_good_valid", 128'(tag_valid), 128'd1);
    chk("tag_good_ok",    128'(tag_ok),    128'd1);
    sweep(0, 1023, 1'b0, 1'b1, 800, -1);
    chk("tag_bad_valid",  128'(tag_valid), 128'd1);
    chk("tag_bad_ok",     128'(tag_ok),    128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decryption.md
DECRYPTION -- requirements
Module: decryption

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-003 SHALL have port count_dp, input, 12 bits, the step counter from the ACORN core.
REQ-004 SHALL have port ciphertext_in, input, 128 bits, the ciphertext block; bit i is decrypted at step 384+i.
REQ-005 SHALL have port ks_bit, input, 1 bit, the keystream bit from the core, valid for the current count_dp.
REQ-006 SHALL have port mbit_out, output, 1 bit, the recovered message bit fed back to the core state update.
REQ-007 SHALL have ports ca_out and cb_out, output, 1 bit each, the core control bits.
REQ-008 SHALL have port plaintext_out, output, 128 bits, the assembled plaintext.
REQ-009 SHALL have port pt_valid, output, 1 bit, asserted when plaintext_out is complete.

Function
REQ-010 SHALL derive its phase from count_dp as follows: IDLE (0..383), DATA (384..511), PAD (512), ZERO (513..767), TAG (768..895) and HOLD (896..4095).
REQ-011 SHALL, in DATA, register mbit_out <= ciphertext_in[count_dp-384] ^ ks_bit, which gives one cycle of latency, matching the encryption-side mbit timing.
REQ-012 SHALL, in DATA, write the same bit into plaintext_out[count_dp-384]; all other plaintext_out bits hold.
REQ-013 SHALL register mbit_out <= 1 in PAD and mbit_out <= 0 in IDLE, ZERO, TAG and HOLD.
REQ-014 SHALL register ca_out <= 1 when count_dp <= 639, else 0.
REQ-015 SHALL register cb_out <= 0 on every cycle.
REQ-016 SHALL set pt_valid on the edge where count_dp == 512.
REQ-017 SHALL clear pt_valid on the edge where count_dp == 0; count_dp == 0 starts a new run.
REQ-018 SHALL use only count_dp to select the phase: non-monotonic or skipped counts are decoded by value, with no internal counter.
REQ-019 SHALL compute the bit index as the 7-bit truncation of count_dp-384, used only inside DATA.

Reset
REQ-020 SHALL, on rst high at a clock edge, set mbit_out=0, ca_out=0, cb_out=0, plaintext_out=0 and pt_valid=0, whatever the count_dp value.
REQ-021 SHALL give rst priority over all other updates; a reset mid-DATA discards the partial plaintext.

Configuration
REQ-022 SHALL support the macro DECRYPTION_TAG_CHECK_EN.
REQ-023 SHALL, with DECRYPTION_TAG_CHECK_EN defined, add input tag_in (128 bits) and outputs tag_valid and tag_ok (1 bit each).
REQ-024 SHALL, with the macro defined, set a sticky mismatch flag during TAG when ks_bit != tag_in[count_dp-768].
REQ-025 SHALL, with the macro defined, register tag_valid <= 1 and tag_ok <= ~mismatch on the edge where count_dp == 896.
REQ-026 SHALL, with the macro defined, clear mismatch, tag_valid and tag_ok on rst or when count_dp == 0.
REQ-027 SHALL, without DECRYPTION_TAG_CHECK_EN, omit those ports and their logic entirely, with all other behaviour unchanged.

Structure
REQ-028 SHALL take the phase boundary constants (384, 511, 512, 639, 767, 768, 895, 896) and a phase enumeration from the shared package acorn_pkg, also used by encryption.
REQ-029 SHALL place the tag logic in one sub-module, decryption_tag_check, instantiated only under DECRYPTION_TAG_CHECK_EN.

Verification
REQ-030 SHALL cover: rst=1 held while count_dp=450 -> all outputs 0 and plaintext_out=0 on the next edge.
REQ-031 SHALL cover: ciphertext_in=0, ks_bit=1, count_dp swept 0..1023 -> mbit_out=1 after counts 384..512, 0 elsewhere; plaintext_out=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; pt_valid rises after the count 512 edge.
REQ-032 SHALL cover: ciphertext_in=128'h8000_0000_0000_0000_0000_0000_0000_0001, ks_bit=0 -> plaintext_out equals ciphertext_in; mbit_out high only after counts 384, 511 and 512.
REQ-033 SHALL cover: count_dp sweep -> ca_out=1 after the count 639 edge, 0 after the count 640 edge; cb_out=0 throughout.
REQ-034 SHALL cover: macro defined, ks_bit equal to tag_in[count_dp-768] in TAG -> tag_valid=1 and tag_ok=1 after count 896; with ks_bit inverted at count 800 only -> tag_ok=0.
REQ-035 SHALL cover: rst pulse at count_dp=450, then the sweep resumed from 0 -> pt_valid=0 until count 512, and the final plaintext_out correct.
